// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: qualifies the start bit, times mid-bit sampling for the
// external SIPO shift register, and checks the stop bit of each frame.
module uart_rx_sequencer #(
    parameter int unsigned CLOCKS_PER_BIT   = 16,
    parameter int unsigned INPUT_DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic serial_in_synced,
    output logic sampling_strobe,
    output logic data_is_available,
    output logic data_is_valid,
    output logic framing_error,
    output logic rx_busy
);

    localparam logic [15:0] BaudLast = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [15:0] BaudPre  = 16'(CLOCKS_PER_BIT - 2);
    localparam logic [15:0] HalfLast = 16'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [3:0]  BitLast  = 4'(INPUT_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreakWait
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        strobe_q, strobe_d;
    logic        avail_q, avail_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    // State, counters and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            strobe_q   <= 1'b0;
            avail_q    <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            strobe_q   <= strobe_d;
            avail_q    <= avail_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, counter updates and next values of the output registers.
    // Pulses are decided one cycle ahead (baud_cnt == CLOCKS_PER_BIT-2) so that the
    // registered pulse coincides with the baud_cnt == CLOCKS_PER_BIT-1 sample point.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        strobe_d   = 1'b0;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!serial_in_synced) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_cnt_q == HalfLast) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // A line back high at mid start bit was a glitch.
                    state_d    = serial_in_synced ? StIdle : StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StData: begin
                strobe_d = (baud_cnt_q == BaudPre);
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (baud_cnt_q == BaudPre) begin
                    valid_d = serial_in_synced;
                    ferr_d  = ~serial_in_synced;
                end
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    // ferr_q holds the stop-bit verdict during this cycle.
                    state_d    = ferr_q ? StBreakWait : StIdle;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            StBreakWait: begin
                // Wait out a break; a low line here never starts a frame.
                if (serial_in_synced) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        avail_d = (state_d == StData);
        busy_d  = (state_d != StIdle);
    end

    assign sampling_strobe   = strobe_q;
    assign data_is_available = avail_q;
    assign data_is_valid     = valid_q;
    assign framing_error     = ferr_q;
    assign rx_busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: one instance at 16 clocks/bit, one at 5.
module tb_uart_rx_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;

    logic strobe_a, avail_a, valid_a, ferr_a, busy_a;
    logic strobe_b, avail_b, valid_b, ferr_b, busy_b;

    uart_rx_sequencer #(.CLOCKS_PER_BIT(16), .INPUT_DATA_WIDTH(8)) dut_a (
        .clk               (clk),
        .reset_n           (reset_n),
        .serial_in_synced  (line_a),
        .sampling_strobe   (strobe_a),
        .data_is_available (avail_a),
        .data_is_valid     (valid_a),
        .framing_error     (ferr_a),
        .rx_busy           (busy_a)
    );

    uart_rx_sequencer #(.CLOCKS_PER_BIT(5), .INPUT_DATA_WIDTH(8)) dut_b (
        .clk               (clk),
        .reset_n           (reset_n),
        .serial_in_synced  (line_b),
        .sampling_strobe   (strobe_b),
        .data_is_available (avail_b),
        .data_is_valid     (valid_b),
        .framing_error     (ferr_b),
        .rx_busy           (busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Event logs (cycle numbers) and a model of the downstream shift register.
    int st_a[$], va_a[$], fe_a[$], bu_a[$], wd_a[$];
    int st_b[$], va_b[$], wd_b[$];
    int n_av_a = 0;
    int n_clash = 0;
    logic [7:0] sr_a = 8'h00;
    logic [7:0] sr_b = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            sr_a = 8'h00;
            sr_b = 8'h00;
        end
        if (strobe_a) begin
            st_a.push_back(cyc);
            if (avail_a) sr_a = {line_a, sr_a[7:1]};
        end
        if (strobe_b) begin
            st_b.push_back(cyc);
            if (avail_b) sr_b = {line_b, sr_b[7:1]};
        end
        if (valid_a) begin
            va_a.push_back(cyc);
            wd_a.push_back(int'(sr_a));
            sr_a = 8'h00;
        end
        if (valid_b) begin
            va_b.push_back(cyc);
            wd_b.push_back(int'(sr_b));
            sr_b = 8'h00;
        end
        if (ferr_a) fe_a.push_back(cyc);
        if (busy_a) bu_a.push_back(cyc);
        if (avail_a) n_av_a++;
        if ((valid_a && ferr_a) || (strobe_a && valid_a)) n_clash++;
        if ((valid_b && ferr_b) || (strobe_b && valid_b)) n_clash++;
    end

    function automatic logic [31:0] qat(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a line level for n cycles starting with the current one.
    task automatic drive(input int sel, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) line_a = b;
            else line_b = b;
            tick();
        end
    endtask

    task automatic send(input int sel, input logic [7:0] w, input logic stop, input int cpb,
                        input int stop_len);
        drive(sel, 1'b0, cpb);
        for (int k = 0; k < 8; k++) drive(sel, w[k], cpb);
        drive(sel, stop, stop_len);
    endtask

    int t0, t1, s0, v0, f0, b0, av0;

    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) tick();
        chk("reset_outs_a", {27'd0, strobe_a, avail_a, valid_a, ferr_a, busy_a}, 32'd0);
        chk("reset_outs_b", {27'd0, strobe_b, avail_b, valid_b, ferr_b, busy_b}, 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // 1: 0xA5, good stop
        s0 = st_a.size(); v0 = va_a.size(); f0 = fe_a.size(); b0 = bu_a.size(); av0 = n_av_a;
        t0 = cyc;
        send(0, 8'hA5, 1'b1, 16, 16);
        drive(0, 1'b1, 8);
        chk("t1_strobes", st_a.size() - s0, 8);
        chk("t1_first_strobe", qat(st_a, s0) - t0, 24);
        chk("t1_last_strobe", qat(st_a, s0 + 7) - t0, 136);
        chk("t1_valids", va_a.size() - v0, 1);
        chk("t1_valid_cyc", qat(va_a, v0) - t0, 152);
        chk("t1_word", qat(wd_a, v0), 32'hA5);
        chk("t1_ferr", fe_a.size() - f0, 0);
        chk("t1_avail_cycles", n_av_a - av0, 128);
        chk("t1_busy_cycles", bu_a.size() - b0, 152);

        // 2: 5-cycle glitch
        s0 = st_a.size(); v0 = va_a.size(); f0 = fe_a.size(); b0 = bu_a.size();
        t0 = cyc;
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 20);
        chk("t2_strobes", st_a.size() - s0, 0);
        chk("t2_valids", va_a.size() - v0, 0);
        chk("t2_ferr", fe_a.size() - f0, 0);
        chk("t2_busy_cycles", bu_a.size() - b0, 8);
        chk("t2_busy_first", qat(bu_a, b0) - t0, 1);
        chk("t2_busy_last", qat(bu_a, b0 + 7) - t0, 8);

        // 3: 0x3C with low stop bit, 40-cycle break, then 0x81
        s0 = st_a.size(); v0 = va_a.size(); f0 = fe_a.size();
        t0 = cyc;
        send(0, 8'h3C, 1'b0, 16, 56);
        chk("t3_busy_in_break", {31'd0, busy_a}, 32'd1);
        drive(0, 1'b1, 1);
        chk("t3_idle_after_break", {31'd0, busy_a}, 32'd0);
        chk("t3_ferr", fe_a.size() - f0, 1);
        chk("t3_ferr_cyc", qat(fe_a, f0) - t0, 152);
        chk("t3_valids", va_a.size() - v0, 0);
        chk("t3_strobes", st_a.size() - s0, 8);
        drive(0, 1'b1, 4);
        v0 = va_a.size();
        send(0, 8'h81, 1'b1, 16, 16);
        drive(0, 1'b1, 8);
        chk("t3_next_valids", va_a.size() - v0, 1);
        chk("t3_next_word", qat(wd_a, v0), 32'h81);

        // 4: back-to-back 0x00 then 0xFF
        v0 = va_a.size();
        t0 = cyc;
        send(0, 8'h00, 1'b1, 16, 9);
        t1 = cyc;
        send(0, 8'hFF, 1'b1, 16, 16);
        drive(0, 1'b1, 8);
        chk("t4_valids", va_a.size() - v0, 2);
        chk("t4_valid0_cyc", qat(va_a, v0) - t0, 152);
        chk("t4_gap", qat(va_a, v0 + 1) - qat(va_a, v0), 153);
        chk("t4_word0", qat(wd_a, v0), 32'h00);
        chk("t4_word1", qat(wd_a, v0 + 1), 32'hFF);

        // 5: reset at t0+70 during 0x5A
        v0 = va_a.size();
        t0 = cyc;
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 6);
        chk("t5_at_reset_cyc", cyc - t0, 70);
        chk("t5_avail_before", {31'd0, avail_a}, 32'd1);
        reset_n = 1'b0;
        line_a = 1'b1;
        #1;
        chk("t5_outs_in_reset", {27'd0, strobe_a, avail_a, valid_a, ferr_a, busy_a}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        drive(0, 1'b1, 200);
        chk("t5_idle_after", {31'd0, busy_a}, 32'd0);
        chk("t5_no_valid", va_a.size() - v0, 0);
        send(0, 8'h5A, 1'b1, 16, 16);
        drive(0, 1'b1, 8);
        chk("t5_next_valids", va_a.size() - v0, 1);
        chk("t5_next_word", qat(wd_a, v0), 32'h5A);

        // 6: CLOCKS_PER_BIT=5, 0x96
        s0 = st_b.size(); v0 = va_b.size();
        t0 = cyc;
        send(1, 8'h96, 1'b1, 5, 5);
        drive(1, 1'b1, 8);
        chk("t6_strobes", st_b.size() - s0, 8);
        chk("t6_first_strobe", qat(st_b, s0) - t0, 7);
        chk("t6_strobe_spacing", qat(st_b, s0 + 1) - qat(st_b, s0), 5);
        chk("t6_last_strobe", qat(st_b, s0 + 7) - t0, 42);
        chk("t6_valids", va_b.size() - v0, 1);
        chk("t6_valid_cyc", qat(va_b, v0) - t0, 47);
        chk("t6_word", qat(wd_b, v0), 32'h96);

        chk("exclusive_pulses", n_clash, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
